// File: rtl/disp_scan_ctrl.sv
// Signed 16-bit value to multiplexed 4-slot seven-segment scanner with a
// 6-character scrollable window; binary-to-BCD conversion is double-dabble.
module disp_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        scroll,
  output logic        busy,
  output logic        done,
  output logic [1:0]  toggle,
  output logic [3:0]  digit_code
);

  localparam int unsigned MAG_W  = 16;
  localparam int unsigned BCD_W  = 20;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DIV_W  = $clog2(REFRESH_DIV);
  localparam int unsigned CHAR_W = 4;

  localparam logic [CHAR_W-1:0] CH_MINUS = 4'd10;
  localparam logic [CHAR_W-1:0] CH_BLANK = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  state_t state, next_state;

  logic [BCD_W-1:0]      bcd;
  logic [MAG_W-1:0]      mag;
  logic                  sign;
  logic [CNT_W-1:0]      cnt;
  logic [4:0][3:0]       disp_dig;
  logic                  disp_neg;
  logic [DIV_W-1:0]      div;
  logic [1:0]            w;
  logic [5:0][3:0]       chars;
  logic                  zero_above;
  logic [2:0]            sel;

  // Add 3 to every BCD nibble >= 5 ahead of the doubling shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
      done  <= (next_state == S_COMMIT);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (load) next_state = S_CONVERT;
      S_CONVERT: if (cnt == 4'd15) next_state = S_COMMIT;
      S_COMMIT:  next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Conversion datapath and committed display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd      <= '0;
      mag      <= '0;
      sign     <= 1'b0;
      cnt      <= '0;
      disp_dig <= '0;
      disp_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            sign <= value[15];
            mag  <= value[15] ? MAG_W'(~value + 16'd1) : value;
            bcd  <= '0;
            cnt  <= '0;
          end
        end
        S_CONVERT: begin
          {bcd, mag} <= {bcd_adjust(bcd), mag} << 1;
          cnt        <= cnt + 4'd1;
        end
        S_COMMIT: begin
          disp_dig <= bcd;
          disp_neg <= sign && (bcd != '0);
        end
        default: ;
      endcase
    end
  end

  // Slot refresh divider and scroll window run regardless of conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      toggle <= 2'd0;
      w      <= 2'd0;
    end else begin
      if (div == DIV_W'(REFRESH_DIV - 1)) begin
        div    <= '0;
        toggle <= toggle + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      if (scroll) w <= (w == 2'd2) ? 2'd0 : w + 2'd1;
    end
  end

  // Leading-zero blanking with the minus sign just above the top nonzero digit.
  always_comb begin
    chars      = {6{CH_BLANK}};
    zero_above = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      if (!zero_above || disp_dig[3'(i)] != 4'd0 || i == 0)
        chars[3'(i)] = disp_dig[3'(i)];
      if (disp_neg && zero_above && disp_dig[3'(i)] != 4'd0)
        chars[3'(i + 1)] = CH_MINUS;
      zero_above = zero_above && (disp_dig[3'(i)] == 4'd0);
    end
  end

  assign sel        = 3'(toggle) + 3'(w);
  assign digit_code = chars[sel];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl against a decimal-string reference model.
module tb_disp_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        scroll;
  logic        busy;
  logic        done;
  logic [1:0]  toggle;
  logic [3:0]  digit_code;

  int n_cmp   = 0;
  int n_err   = 0;
  int ncyc    = 0;
  int w_model = 0;
  int exp_val = 0;

  disp_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .scroll     (scroll),
    .busy       (busy),
    .done       (done),
    .toggle     (toggle),
    .digit_code (digit_code)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the scan slot follows from this.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Character at position pos of the decimal rendering of v, right-aligned.
  function automatic int model_char(input int v, input int pos);
    int mag, nd, p;
    mag = (v < 0) ? -v : v;
    nd  = 1;
    for (int t = mag / 10; t > 0; t = t / 10) nd++;
    if (pos < nd) begin
      p = 1;
      for (int k = 0; k < pos; k++) p = p * 10;
      return (mag / p) % 10;
    end
    if (pos == nd && v < 0) return 10;
    return 15;
  endfunction

  task automatic check_slots(input int n);
    int slot;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      slot = (ncyc / DIV) % 4;
      chk("toggle", 32'(toggle), 32'(slot));
      chk("digit_code", 32'(digit_code), 32'(model_char(exp_val, slot + w_model)));
    end
  endtask

  task automatic do_scroll();
    @(negedge clk);
    scroll = 1'b1;
    @(negedge clk);
    scroll = 1'b0;
    w_model = (w_model + 1) % 3;
  endtask

  task automatic load_val(input int v, input bit with_scroll);
    int lat;
    @(negedge clk);
    value  = 16'(v);
    load   = 1'b1;
    scroll = with_scroll;
    @(negedge clk);
    load   = 1'b0;
    scroll = 1'b0;
    if (with_scroll) w_model = (w_model + 1) % 3;
    chk("busy_start", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd17);
    chk("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_pulse_len", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    exp_val = v;
  endtask

  int fixed_vals [10] = '{1234, -16384, -7, 0, -32768, 32767, -1, 10, 100, -9999};

  initial begin
    int ndone;
    int v;
    logic signed [15:0] r;

    rst_n  = 1'b0;
    load   = 1'b0;
    scroll = 1'b0;
    value  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_toggle", 32'(toggle), 32'd0);
    chk("rst_digit", 32'(digit_code), 32'd0);
    rst_n = 1'b1;
    check_slots(16);

    // Directed values, each viewed at all three window positions.
    foreach (fixed_vals[i]) begin
      load_val(fixed_vals[i], 1'b0);
      check_slots(16);
      do_scroll();
      check_slots(16);
      do_scroll();
      check_slots(16);
      do_scroll();
      check_slots(8);
    end

    // Load during conversion is dropped.
    @(negedge clk);
    value = 16'd5;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    value = 16'd9;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("single_done", 32'(ndone), 32'd1);
    exp_val = 5;
    check_slots(16);

    // Reset in the middle of a conversion.
    @(negedge clk);
    value = 16'd1234;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_toggle", 32'(toggle), 32'd0);
    chk("abort_digit", 32'(digit_code), 32'd0);
    w_model = 0;
    exp_val = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    check_slots(8);
    load_val(42, 1'b0);
    check_slots(16);

    // Random values with scrolls, some coinciding with the load.
    for (int n = 0; n < 30; n++) begin
      r = 16'($urandom);
      v = r;
      load_val(v, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) do_scroll();
      check_slots(8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  single-cycle pulse; capture value and start conversion.
REQ-005 value  input  16  two's-complement product to display.
REQ-006 scroll  input  1  single-cycle pulse; advance display window.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when new digits are committed.
REQ-009 toggle  output  2  active digit slot index, drives the seven-segment decoder select.
REQ-010 digit_code  output  4  character code for the active slot: 0-9 digit, 10 minus, 15 blank.

Function
REQ-011 FSM states IDLE, CONVERT, COMMIT; IDLE->CONVERT on load, CONVERT->COMMIT after 16 shift cycles, COMMIT->IDLE unconditionally.
REQ-012 On load in IDLE: latch sign = value[15] and magnitude = |value| as 16-bit unsigned (-32768 -> 32768); clear 20-bit BCD accumulator.
REQ-013 CONVERT: per cycle, add 3 to every BCD nibble >= 5, then shift {BCD, magnitude} left 1; exactly 16 cycles, counted by a 4-bit counter.
REQ-014 COMMIT: copy the 5 BCD digits d4..d0 and sign into display registers; done = 1 for this cycle only.
REQ-015 Latency: load in cycle N -> done in cycle N+17; busy high from N+1 through N+17 inclusive.
REQ-016 load while busy is ignored and not queued; display registers keep the previous result until COMMIT.
REQ-017 Character string c5..c0: c0 = d0 always; ci (i = 1..4) = di, or blank 15 if di and all higher digits are 0; c5 blank.
REQ-018 Minus: if sign = 1 and magnitude != 0, the lowest blank position above the highest nonzero digit shows 10 (c5 when d4 != 0); zero displays as "0", never "-0".
REQ-019 Window register w, 2 bits, values 0..2; scroll increments w, 2 wraps to 0; value 3 unreachable.
REQ-020 digit_code = c(toggle + w); slot 0 (toggle = 0) is the rightmost anode.
REQ-021 Refresh divider counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and toggle increments mod 4 (3 -> 0).
REQ-022 Refresh and scroll operate in every FSM state; conversion never stalls scanning.
REQ-023 digit_code is registered-free combinational from display registers, w and toggle; it changes only on the clk edge that updates one of them.
REQ-024 Simultaneous load and scroll: both take effect in the same cycle.

Reset
REQ-025 rst_n low, asynchronously: FSM = IDLE, busy = 0, done = 0, toggle = 0, divider = 0, w = 0, BCD and display digits = 0, sign = 0 (display shows "0" right-aligned, rest blank).
REQ-026 rst_n asserted mid-CONVERT aborts conversion; no done pulse is issued for the aborted load.
REQ-027 First load accepted on the first rising edge after rst_n deasserts.

Verification
REQ-028 load value = 16'd1234 -> done at +17 cycles; toggle 3..0 codes = 1,2,3,4 with w = 0.
REQ-029 load value = -16384 (16'hC000) -> w = 0 slots 3..0 = 6,3,8,4; w = 1 slots 3..0 = 1,6,3,8; w = 2 slot 3 = 10, slot 2 = 1.
REQ-030 load value = -7 -> slots 3..0 = 15,15,10,7; load value = 0 -> 15,15,15,0.
REQ-031 load 16'd5, then load 16'd9 three cycles later -> second load ignored, display shows 5, single done pulse.
REQ-032 REFRESH_DIV = 4: toggle sequence 0,1,2,3,0 changing every 4 cycles; scroll x3 returns w to 0.
REQ-033 rst_n low at cycle 8 of CONVERT -> busy = 0 immediately, no done, display shows "0"; subsequent load 16'd42 displays 42.
